// File: rtl/service_arbiter_if.sv
// rtl/service_arbiter_if.sv - board/service side signal bundle for the alarm clock mode arbiter
//
// Groups every signal of service_arbiter except clock and reset.
//   master : board side -- drives tick_1hz, push, svc_sw, alarm_en, alarm_hit, game_done;
//            observes mode, mode_change, btn_*, game_start, ringing
//   slave  : the arbiter itself (directions mirrored)
interface service_arbiter_if;
    logic       tick_1hz;
    logic [4:0] push;
    logic [2:0] svc_sw;
    logic       alarm_en;
    logic       alarm_hit;
    logic       game_done;
    logic [2:0] mode;
    logic       mode_change;
    logic [4:0] btn_time;
    logic [4:0] btn_alarm;
    logic [4:0] btn_sw;
    logic [4:0] btn_game;
    logic       game_start;
    logic       ringing;

    modport master (
        output tick_1hz, push, svc_sw, alarm_en, alarm_hit, game_done,
        input  mode, mode_change, btn_time, btn_alarm, btn_sw, btn_game, game_start, ringing
    );

    modport slave (
        input  tick_1hz, push, svc_sw, alarm_en, alarm_hit, game_done,
        output mode, mode_change, btn_time, btn_alarm, btn_sw, btn_game, game_start, ringing
    );
endinterface

// File: rtl/service_arbiter.sv
// rtl/service_arbiter.sv - alarm clock mode controller: button debounce, service grant and press routing
//
// Ports:
//   clk_osc   - 100 MHz system clock
//   rst       - synchronous active-high reset
//   bus.slave - tick_1hz, push[4:0], svc_sw[2:0], alarm_en, alarm_hit, game_done in;
//               mode[2:0], mode_change, btn_time/btn_alarm/btn_sw/btn_game[4:0],
//               game_start, ringing out
// Parameters:
//   DEB_CYCLES - consecutive differing samples before a button level is accepted
//   RING_SECS  - tick_1hz pulses after which an unanswered alarm stops ringing
module service_arbiter #(
    parameter logic [19:0] DEB_CYCLES = 20'd1000000,
    parameter logic [7:0]  RING_SECS  = 8'd60
) (
    input  logic             clk_osc,
    input  logic             rst,
    service_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_CLOCK     = 3'd0,
        MODE_TIME_SET  = 3'd1,
        MODE_ALARM_SET = 3'd2,
        MODE_STOPWATCH = 3'd3,
        MODE_RING      = 3'd4,
        MODE_GAME      = 3'd5
    } mode_t;

    // ------------------------------------------------------------------
    // Debounce: one counter per button, counting consecutive cycles in
    // which the raw level disagrees with the accepted level.
    // ------------------------------------------------------------------
    logic [4:0]  r_stable;
    logic [4:0]  r_press;
    logic [19:0] r_deb_cnt [5];

    always_ff @(posedge clk_osc) begin
        if (rst) begin
            r_stable <= 5'd0;
            r_press  <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                r_deb_cnt[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                r_press[i] <= 1'b0;
                if (bus.push[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= 20'd0;
                end else if (r_deb_cnt[i] == DEB_CYCLES - 20'd1) begin
                    r_stable[i]  <= bus.push[i];
                    r_deb_cnt[i] <= 20'd0;
                    // Only the 0->1 acceptance is a press; releases stay silent.
                    r_press[i]   <= bus.push[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 20'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    mode_t      r_mode;
    logic       r_mode_change;
    logic       r_game_start;
    logic [7:0] r_ring_secs;

    mode_t      w_sw_mode;
    mode_t      w_next_mode;
    logic [4:0] w_press_ok;
    logic       w_ring_timeout;

    // A press that lands in the first cycle of a new mode belongs to no one.
    assign w_press_ok     = r_press & {5{~r_mode_change}};
    assign w_ring_timeout = bus.tick_1hz && (r_ring_secs == RING_SECS - 8'd1);

    always_comb begin
        w_sw_mode = MODE_CLOCK;
        if (bus.svc_sw[2]) begin
            w_sw_mode = MODE_TIME_SET;
        end else if (bus.svc_sw[1]) begin
            w_sw_mode = MODE_ALARM_SET;
        end else if (bus.svc_sw[0]) begin
            w_sw_mode = MODE_STOPWATCH;
        end
    end

    always_comb begin
        w_next_mode = r_mode;
        case (r_mode)
            MODE_RING: begin
                // alarm_en low beats timeout, timeout beats the middle press.
                if (!bus.alarm_en || w_ring_timeout) begin
                    w_next_mode = w_sw_mode;
                end else if (w_press_ok[4]) begin
                    w_next_mode = MODE_GAME;
                end
            end
            MODE_GAME: begin
                if (bus.game_done || !bus.alarm_en) begin
                    w_next_mode = w_sw_mode;
                end
            end
            default: begin
                if (bus.alarm_hit && bus.alarm_en) begin
                    w_next_mode = MODE_RING;
                end else begin
                    w_next_mode = w_sw_mode;
                end
            end
        endcase
    end

    always_ff @(posedge clk_osc) begin
        if (rst) begin
            r_mode        <= MODE_CLOCK;
            r_mode_change <= 1'b0;
            r_game_start  <= 1'b0;
            r_ring_secs   <= 8'd0;
        end else begin
            r_mode        <= w_next_mode;
            r_mode_change <= (w_next_mode != r_mode);
            r_game_start  <= (w_next_mode == MODE_GAME) && (r_mode != MODE_GAME);
            // Held at zero outside RING so every entry starts a fresh count.
            if (r_mode != MODE_RING) begin
                r_ring_secs <= 8'd0;
            end else if (bus.tick_1hz) begin
                r_ring_secs <= r_ring_secs + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Press routing: only the granted service sees the pulse.
    // ------------------------------------------------------------------
    logic [4:0] w_btn_time;
    logic [4:0] w_btn_alarm;
    logic [4:0] w_btn_sw;
    logic [4:0] w_btn_game;

    always_comb begin
        w_btn_time  = 5'd0;
        w_btn_alarm = 5'd0;
        w_btn_sw    = 5'd0;
        w_btn_game  = 5'd0;
        case (r_mode)
            MODE_TIME_SET:  w_btn_time  = w_press_ok;
            MODE_ALARM_SET: w_btn_alarm = w_press_ok;
            MODE_STOPWATCH: w_btn_sw    = w_press_ok;
            MODE_GAME:      w_btn_game  = w_press_ok;
            default: ;
        endcase
    end

    assign bus.mode        = r_mode;
    assign bus.mode_change = r_mode_change;
    assign bus.game_start  = r_game_start;
    assign bus.ringing     = (r_mode == MODE_RING) || (r_mode == MODE_GAME);
    assign bus.btn_time    = w_btn_time;
    assign bus.btn_alarm   = w_btn_alarm;
    assign bus.btn_sw      = w_btn_sw;
    assign bus.btn_game    = w_btn_game;

endmodule

// File: tb/tb_service_arbiter.sv
// tb/tb_service_arbiter.sv - self-checking bench for service_arbiter against a behavioural model
module tb_service_arbiter;

    localparam int DEB   = 4;
    localparam int RSECS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    service_arbiter_if bus ();

    service_arbiter #(
        .DEB_CYCLES (20'd4),
        .RING_SECS  (8'd3)
    ) dut (
        .clk_osc (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: mode as an integer, debounce as a window of the
    // last DEB raw samples (a level is accepted once the whole window
    // disagrees with the current accepted level).
    // ------------------------------------------------------------------
    int           m_mode;
    bit           m_mc;
    bit           m_gs;
    bit [4:0]     m_press;
    bit [4:0]     m_stable;
    bit [DEB-1:0] m_hist [5];
    int           m_ticks;

    function automatic int sw_mode_of(input logic [2:0] s);
        if (s[2]) return 1;
        if (s[1]) return 2;
        if (s[0]) return 3;
        return 0;
    endfunction

    task automatic model_step();
        int       sw;
        int       nxt;
        int       ticks;
        bit [4:0] eff;
        bit [4:0] new_press;
        if (rst) begin
            m_mode   = 0;
            m_mc     = 0;
            m_gs     = 0;
            m_press  = 0;
            m_stable = 0;
            m_ticks  = 0;
            for (int b = 0; b < 5; b++) m_hist[b] = '0;
            return;
        end
        sw    = sw_mode_of(bus.svc_sw);
        nxt   = m_mode;
        eff   = m_mc ? 5'd0 : m_press;
        ticks = m_ticks + (bus.tick_1hz ? 1 : 0);
        if (m_mode == 4) begin
            if (!bus.alarm_en)      nxt = sw;
            else if (ticks >= RSECS) nxt = sw;
            else if (eff[4])         nxt = 5;
        end else if (m_mode == 5) begin
            if (bus.game_done || !bus.alarm_en) nxt = sw;
        end else begin
            if (bus.alarm_hit && bus.alarm_en) nxt = 4;
            else                               nxt = sw;
        end
        new_press = 0;
        for (int b = 0; b < 5; b++) begin
            m_hist[b] = {m_hist[b][DEB-2:0], bus.push[b]};
            if (m_hist[b] == {DEB{~m_stable[b]}}) begin
                m_stable[b]  = ~m_stable[b];
                new_press[b] = m_stable[b];
            end
        end
        m_gs    = (nxt == 5) && (m_mode != 5);
        m_mc    = (nxt != m_mode);
        m_ticks = (nxt == 4 && m_mode == 4) ? ticks : 0;
        m_mode  = nxt;
        m_press = new_press;
    endtask

    task automatic compare();
        bit [4:0] pr;
        pr = m_mc ? 5'd0 : m_press;
        check("mode",        bus.mode,        m_mode);
        check("mode_change", bus.mode_change, m_mc);
        check("game_start",  bus.game_start,  m_gs);
        check("ringing",     bus.ringing,     (m_mode == 4 || m_mode == 5));
        check("btn_time",    bus.btn_time,    (m_mode == 1) ? pr : 5'd0);
        check("btn_alarm",   bus.btn_alarm,   (m_mode == 2) ? pr : 5'd0);
        check("btn_sw",      bus.btn_sw,      (m_mode == 3) ? pr : 5'd0);
        check("btn_game",    bus.btn_game,    (m_mode == 5) ? pr : 5'd0);
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    endtask

    task automatic pulse_hit();
        bus.alarm_hit = 1'b1;
        cycle(1);
        bus.alarm_hit = 1'b0;
    endtask

    task automatic press(input int b);
        bus.push[b] = 1'b1;
        cycle(6);
        bus.push[b] = 1'b0;
        cycle(6);
    endtask

    initial begin
        bus.tick_1hz  = 1'b0;
        bus.push      = 5'd0;
        bus.svc_sw    = 3'd0;
        bus.alarm_en  = 1'b0;
        bus.alarm_hit = 1'b0;
        bus.game_done = 1'b0;
        rst           = 1'b1;
        cycle(2);
        rst = 1'b0;
        cycle(3);

        // Time set routing, debounce latency and a short glitch.
        bus.svc_sw = 3'b100;
        cycle(2);
        press(0);
        bus.push[0] = 1'b1;
        cycle(3);
        bus.push[0] = 1'b0;
        cycle(6);

        // Switch priority walk.
        bus.svc_sw = 3'b111; cycle(3);
        bus.svc_sw = 3'b011; cycle(3);
        bus.svc_sw = 3'b001; cycle(3);
        bus.svc_sw = 3'b000; cycle(3);

        // Alarm beats a simultaneous switch change, then game.
        bus.alarm_en = 1'b1;
        bus.svc_sw   = 3'b001;
        cycle(3);
        bus.svc_sw = 3'b100;
        pulse_hit();
        cycle(3);
        press(4);
        press(1);
        bus.game_done = 1'b1;
        cycle(1);
        bus.game_done = 1'b0;
        cycle(3);

        // Ring timeout after RSECS ticks.
        bus.svc_sw = 3'b000;
        cycle(2);
        pulse_hit();
        for (int k = 0; k < RSECS; k++) begin
            cycle(2);
            bus.tick_1hz = 1'b1;
            cycle(1);
            bus.tick_1hz = 1'b0;
        end
        cycle(4);

        // Ring cut short by alarm_en dropping after one tick.
        pulse_hit();
        cycle(2);
        bus.tick_1hz = 1'b1;
        cycle(1);
        bus.tick_1hz = 1'b0;
        bus.alarm_en = 1'b0;
        cycle(3);
        bus.alarm_en = 1'b1;
        cycle(2);

        // Reset from GAME.
        pulse_hit();
        cycle(2);
        press(4);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        cycle(3);

        // alarm_hit with alarm_en low is ignored.
        bus.alarm_en = 1'b0;
        pulse_hit();
        cycle(3);
        bus.alarm_en = 1'b1;

        // Randomized soak.
        for (int k = 0; k < 4000; k++) begin
            rst           = ($urandom_range(0, 599) == 0);
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 7) == 0) bus.push[b] = ~bus.push[b];
            end
            if ($urandom_range(0, 39) == 0) bus.svc_sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) bus.alarm_en = ~bus.alarm_en;
            bus.alarm_hit = ($urandom_range(0, 29) == 0);
            bus.tick_1hz  = ($urandom_range(0, 9) == 0);
            bus.game_done = ($urandom_range(0, 39) == 0);
            cycle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/service_arbiter.md
Name: service_arbiter

Overview:
- Top-level mode controller for the digital alarm clock.
- Decides which service owns the push buttons and the display: clock display, time set, alarm set, stopwatch, alarm ringing, or the dismissal mini-game.
- Debounces the five push buttons, turns each press into a one-cycle pulse, and routes that pulse only to the service that currently holds the grant.
- Sits between the board inputs (push, spdt) and the service datapaths / display mux inside Main.

Parameters:
- DEB_CYCLES, 20'd1000000: consecutive stable cycles needed before a button level is accepted (use 4 in simulation).
- RING_SECS, 8'd60: number of tick_1hz pulses after which an unanswered alarm stops ringing.

Ports:
- clk_osc  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset, driven from spdt[0].
- tick_1hz  in  1  one-cycle pulse, once per second, from the timekeeper.
- push  in  5  synchronized buttons: [0]=up, [1]=down, [2]=left, [3]=right, [4]=middle.
- svc_sw  in  3  service switches: [2]=time set (spdt[14]), [1]=alarm set (spdt[13]), [0]=stopwatch (spdt[12]).
- alarm_en  in  1  alarm enable, from spdt[11].
- alarm_hit  in  1  one-cycle pulse when current time equals the alarm time.
- game_done  in  1  one-cycle pulse from the mini-game when it is solved.
- mode  out  3  active service: 0=CLOCK, 1=TIME_SET, 2=ALARM_SET, 3=STOPWATCH, 4=RING, 5=GAME.
- mode_change  out  1  one-cycle pulse in the first cycle of a new mode.
- btn_time  out  5  button pulses for TIME_SET.
- btn_alarm  out  5  button pulses for ALARM_SET.
- btn_sw  out  5  button pulses for STOPWATCH.
- btn_game  out  5  button pulses for GAME.
- game_start  out  1  one-cycle pulse when entering GAME.
- ringing  out  1  high while mode is RING or GAME.

Behaviour:
- Reset:
  - mode=0; all other outputs 0.
  - Every debouncer: stable=0, counter=0. Ring second counter=0.
- Debounce (per button, independent):
  - Counter increments while raw != stable and clears when raw == stable.
  - On reaching DEB_CYCLES-1, stable takes raw and the counter clears.
  - Press pulse (stable 0->1 edge) is registered. If raw rises at cycle t and stays high, the pulse is high in cycle t+DEB_CYCLES only.
  - Releases make no pulse.
  - A button held through reset release gives one pulse DEB_CYCLES cycles after reset deasserts.
- Switch decode, sw_mode:
  - Priority svc_sw[2] > svc_sw[1] > svc_sw[0].
  - If no switch is on, sw_mode=CLOCK.
- Transitions (all registered, 1-cycle latency; mode_change pulses in the cycle the new mode first appears):
  - CLOCK/TIME_SET/ALARM_SET/STOPWATCH:
    - alarm_hit && alarm_en -> RING. This wins over any simultaneous switch change.
    - Otherwise, if sw_mode != mode, go to sw_mode.
  - RING:
    - Debounced middle press -> GAME, with game_start high in the same cycle GAME first appears.
    - alarm_en==0, or RING_SECS ticks counted since entry -> sw_mode.
    - Priority when events coincide: alarm_en low > timeout > middle press.
    - Switch changes are ignored. The tick counter clears on entry.
  - GAME:
    - game_done or alarm_en==0 -> sw_mode. Both together give the same result.
    - No timeout. Switches are ignored.
  - alarm_hit is ignored in RING and GAME.
- Button routing (combinational from the registered press pulse and mode):
  - TIME_SET -> btn_time; ALARM_SET -> btn_alarm; STOPWATCH -> btn_sw; GAME -> btn_game (all 5 bits).
  - CLOCK: discarded.
  - RING: only middle is consumed internally; nothing is forwarded.
  - Any press pulse in a cycle where mode_change=1 is dropped for every service.
  - The middle press that moves RING->GAME is not forwarded to btn_game.
  - At most one btn_* bus is non-zero in any cycle.
- Reset mid-operation (any mode, including GAME) returns to CLOCK in the next cycle with no mode_change pulse.

Test Plan:
- rst=1 for 2 cycles, then release with all inputs 0 -> mode=0, every output 0, no mode_change pulse.
- DEB_CYCLES=4; svc_sw=3'b100; raw push[0] high at cycle t -> mode=1 with mode_change pulse; btn_time=5'b00001 at t+4 only; other btn buses 0. A 3-cycle glitch on push[0] -> no pulse.
- svc_sw=3'b111 -> mode=1. Drop [2] -> mode=2. Drop [1] -> mode=3. Clear all -> mode=0. Exactly one mode_change pulse per step.
- alarm_en=1, mode=3, alarm_hit pulse in the same cycle svc_sw changes to 3'b100 -> mode=4, ringing=1. push[4] press -> mode=5, game_start pulse, btn_game stays 0. push[1] press -> btn_game=5'b00010. game_done -> mode=1, ringing=0.
- RING_SECS=3: enter RING, apply 3 tick_1hz pulses -> mode returns to sw_mode after the 3rd tick. Repeat with alarm_en dropped after 1 tick -> immediate exit.
- In GAME, assert rst -> mode=0 and game_start/btn buses 0 the next cycle. alarm_hit with alarm_en=0 in CLOCK -> no transition.
